uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive stage that pairs with the UART transmit shift register: it consumes the 1-bit serial stream that transmitter drives (idle-high, start bit 0, 8 data bits LSB first, stop bit 1) and recovers parallel bytes. Mid-bit sampling is timed by an internal clocks-per-bit counter at 115200 baud. Received bytes are presented on a valid/ready holding register. Framing-error and overrun conditions are flagged as single-cycle pulses.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 115200, serial bit rate
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434), clocks per serial bit, integer division
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- i_rx_d  input  1  asynchronous serial line, idle 1
- i_rx_ready  input  1  consumer accepts o_rx_d when high with o_rx_valid
- o_rx_d  output  8  last received byte
- o_rx_valid  output  1  o_rx_d holds an unconsumed byte
- o_frame_err  output  1  1-cycle pulse: stop bit sampled 0
- o_overrun  output  1  1-cycle pulse: new byte overwrote an unconsumed byte
- o_busy  output  1  high whenever FSM is not IDLE

## Operation
- Input: 2-FF synchronizer (sync1, sync2) plus previous-value reg rx_q; all three reset to 0, so a line held low through reset release is never taken as a start bit.
- Falling edge = rx_q==1 && sync2==0; only acted on in IDLE.
- Counters: cnt (9 bits, 0..CLKS_PER_BIT-1), bit_idx (3 bits), shift reg sh[7:0].
- FSM:
  - IDLE: on falling edge -> START, cnt<=0.
  - START: at cnt==CLKS_PER_BIT/2-1 (216) sample sync2: 1 -> IDLE (false start, nothing reported); 0 -> DATA, cnt<=0, bit_idx<=0. Else cnt++.
  - DATA: at cnt==CLKS_PER_BIT-1: sh<={sync2, sh[7:1]}, cnt<=0; bit_idx==7 -> STOP else bit_idx++. Else cnt++.
  - STOP: at cnt==CLKS_PER_BIT-1 sample sync2: 1 -> deliver; 0 -> o_frame_err pulse, byte discarded, o_rx_d/o_rx_valid untouched. Either way -> IDLE.
- Deliver: o_rx_d<=sh, o_rx_valid<=1. If o_rx_valid was 1 and i_rx_ready is 0 that cycle, o_overrun pulses and data is overwritten.
- Handshake: at each edge with o_rx_valid && i_rx_ready, o_rx_valid<=0 unless a delivery occurs on the same edge (delivery wins, valid stays 1, no overrun).
- o_rx_valid asserts independent of i_rx_ready; o_rx_d is stable while o_rx_valid is high and no delivery occurs.
- Line held low after a framing error (break) does not retrigger: a new start requires a 1 then a falling edge.
- Reset mid-frame: immediate return to IDLE, partial byte dropped, no pulses.

## Timing
- Reset values: o_rx_d=8'h00, o_rx_valid=0, o_frame_err=0, o_overrun=0, o_busy=0, state=IDLE, cnt=0, bit_idx=0, sh=0.
- Edge k = first clk edge at which i_rx_d is captured low into sync1. sync2 goes low at k+1; FSM enters START at k+2.
- Start sample at edge k+2+CLKS_PER_BIT/2 (k+219).
- Data bit n (n=0..7) sampled at k+219+(n+1)*CLKS_PER_BIT.
- Stop sample and o_rx_valid/o_frame_err update at k+219+9*CLKS_PER_BIT = k+4125. Total latency = 2+CLKS_PER_BIT/2+9*CLKS_PER_BIT cycles.
- IDLE is re-entered one cycle after the stop sample. Back-to-back frames with no idle gap are received: the stop-to-start falling edge falls half a bit after the stop sample.
- o_frame_err and o_overrun are high for exactly one cycle. o_busy follows the state register.
- Tolerates ±2% baud mismatch: the sample point stays within the bit.

## Test plan
- Reset, line idle, send 0xA5 frame at 115200 -> o_rx_valid rises exactly 4125 cycles after start-bit capture; o_rx_d=0xA5; i_rx_ready=1 then clears valid next edge.
- Back-to-back 0x00 then 0xFF, no idle gap, i_rx_ready held 1 -> two deliveries 0x00, 0xFF; no o_frame_err, no o_overrun.
- Glitch: i_rx_d low for 100 cycles then high -> FSM returns to IDLE at start sample; o_rx_valid, o_frame_err stay 0; next 0x3C frame received correctly.
- Frame 0x3C with stop bit 0 -> o_frame_err 1-cycle pulse at the stop sample; o_rx_valid stays 0; line held low afterwards produces no new frame until high then low.
- i_rx_ready=0, send 0x11 then 0x22 -> second delivery pulses o_overrun; o_rx_d=0x22, o_rx_valid=1.
- rst asserted mid DATA of 0x5A, released with line low -> no valid, no pulses; after line goes high, 0x5A frame received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames on an idle-high line, mid-bit sampled by a clocks-per-bit counter.
// Received bytes sit in a valid/ready holding register; framing error and overrun are one-cycle pulses.
module uart_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx_d,
    input  logic       i_rx_ready,
    output logic [7:0] o_rx_d,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_q;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_sh;
    logic [7:0]       r_rx_d;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       w_sh_nxt;
    logic             w_deliver;
    logic             w_frame_err;
    logic             w_fall;
    logic             w_rx_valid_nxt;
    logic             w_overrun;

    // Synchronizer registers reset low so a line held low across reset never looks like a start edge.
    assign w_fall = r_rx_q & ~r_sync2;

    // Next-state, counter and shift-register logic for the receive FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_sh_nxt      = r_sh;
        w_deliver     = 1'b0;
        w_frame_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt = '0;
                    if (r_sync2) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt   = S_DATA;
                        w_bit_idx_nxt = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    w_sh_nxt  = {r_sync2, r_sh[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (r_sync2) begin
                        w_deliver = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Holding register: a delivery wins over a same-cycle consume, and overwriting an unconsumed byte flags overrun.
    always_comb begin
        w_overrun = w_deliver & r_rx_valid & ~i_rx_ready;
        if (w_deliver) begin
            w_rx_valid_nxt = 1'b1;
        end else if (r_rx_valid && i_rx_ready) begin
            w_rx_valid_nxt = 1'b0;
        end else begin
            w_rx_valid_nxt = r_rx_valid;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_rx_q      <= 1'b0;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_sh        <= 8'h00;
            r_rx_d      <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync1     <= i_rx_d;
            r_sync2     <= r_sync1;
            r_rx_q      <= r_sync2;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_sh        <= w_sh_nxt;
            r_rx_d      <= w_deliver ? r_sh : r_rx_d;
            r_rx_valid  <= w_rx_valid_nxt;
            r_frame_err <= w_frame_err;
            r_overrun   <= w_overrun;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_rx_d      = r_rx_d;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: drives 8N1 frames at 434 clocks per bit
// and checks latency, data, handshake, false start, framing error, overrun and mid-frame reset.
module tb_uart_rx;

    localparam int CPB = 434;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_rx_d;
    logic       i_rx_ready;
    logic [7:0] o_rx_d;
    logic       o_rx_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx_d     (i_rx_d),
        .i_rx_ready (i_rx_ready),
        .o_rx_d     (o_rx_d),
        .o_rx_valid (o_rx_valid),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor sampled on the falling edge: pulse counts, pulse cycles, and bytes seen at valid rise.
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         ferr_cyc = -1;
    int         ovr_cyc  = -1;
    int         rise_cyc = -1;
    logic       prev_valid = 1'b0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        if (o_frame_err === 1'b1) begin
            ferr_cnt = ferr_cnt + 1;
            ferr_cyc = cyc;
        end
        if (o_overrun === 1'b1) begin
            ovr_cnt = ovr_cnt + 1;
            ovr_cyc = cyc;
        end
        if (o_rx_valid === 1'b1 && prev_valid !== 1'b1) begin
            rise_cyc = cyc;
            rx_log.push_back(o_rx_d);
        end
        prev_valid = o_rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        i_rx_d = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Called on a falling edge; k is the rising edge that captures the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, output int k);
        i_rx_d = 1'b0;
        k = cyc + 1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_b);
    endtask

    int k1, k2, bd, bf, bo;

    initial begin
        rst        = 1'b1;
        i_rx_d     = 1'b1;
        i_rx_ready = 1'b0;
        idle(3);
        check("rst_rx_d", 32'(o_rx_d), 32'h00);
        check("rst_valid", 32'(o_rx_valid), 32'd0);
        check("rst_ferr", 32'(o_frame_err), 32'd0);
        check("rst_ovr", 32'(o_overrun), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        idle(20);

        // Single frame 0xA5, consumer not ready yet
        bd = rx_log.size(); bf = ferr_cnt;
        send_frame(8'hA5, 1'b1, k1);
        check("a5_latency", 32'(rise_cyc - k1), 32'(LAT));
        check("a5_count", 32'(rx_log.size() - bd), 32'd1);
        check("a5_data", 32'(o_rx_d), 32'hA5);
        check("a5_valid", 32'(o_rx_valid), 32'd1);
        check("a5_busy", 32'(o_busy), 32'd0);
        check("a5_ferr", 32'(ferr_cnt - bf), 32'd0);
        i_rx_ready = 1'b1;
        idle(1);
        check("a5_consumed", 32'(o_rx_valid), 32'd0);

        // Back-to-back 0x00 then 0xFF, no idle gap
        bd = rx_log.size(); bf = ferr_cnt; bo = ovr_cnt;
        send_frame(8'h00, 1'b1, k1);
        send_frame(8'hFF, 1'b1, k2);
        check("b2b_count", 32'(rx_log.size() - bd), 32'd2);
        check("b2b_first", 32'(rx_log[bd]), 32'h00);
        check("b2b_second", 32'(rx_log[bd + 1]), 32'hFF);
        check("b2b_latency", 32'(rise_cyc - k2), 32'(LAT));
        check("b2b_ferr", 32'(ferr_cnt - bf), 32'd0);
        check("b2b_ovr", 32'(ovr_cnt - bo), 32'd0);

        // 100-cycle glitch is rejected at the start sample
        idle(10);
        bd = rx_log.size(); bf = ferr_cnt;
        i_rx_d = 1'b0;
        idle(50);
        check("glitch_busy", 32'(o_busy), 32'd1);
        idle(50);
        i_rx_d = 1'b1;
        idle(300);
        check("glitch_idle", 32'(o_busy), 32'd0);
        check("glitch_valid", 32'(o_rx_valid), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - bf), 32'd0);
        check("glitch_count", 32'(rx_log.size() - bd), 32'd0);
        send_frame(8'h3C, 1'b1, k1);
        check("post_glitch_count", 32'(rx_log.size() - bd), 32'd1);
        check("post_glitch_data", 32'(rx_log[rx_log.size() - 1]), 32'h3C);

        // Stop bit 0: framing error, then a held-low line must not retrigger
        idle(10);
        bd = rx_log.size(); bf = ferr_cnt;
        send_frame(8'h3C, 1'b0, k1);
        check("ferr_count", 32'(ferr_cnt - bf), 32'd1);
        check("ferr_timing", 32'(ferr_cyc - k1), 32'(LAT));
        check("ferr_no_deliver", 32'(rx_log.size() - bd), 32'd0);
        check("ferr_valid", 32'(o_rx_valid), 32'd0);
        idle(1000);
        check("break_busy", 32'(o_busy), 32'd0);
        check("break_ferr", 32'(ferr_cnt - bf), 32'd1);
        i_rx_d = 1'b1;
        idle(CPB);
        send_frame(8'h96, 1'b1, k1);
        check("post_break_count", 32'(rx_log.size() - bd), 32'd1);
        check("post_break_data", 32'(rx_log[rx_log.size() - 1]), 32'h96);

        // Overrun: consumer stalled across two deliveries
        i_rx_ready = 1'b0;
        idle(10);
        bd = rx_log.size(); bf = ferr_cnt; bo = ovr_cnt;
        send_frame(8'h11, 1'b1, k1);
        send_frame(8'h22, 1'b1, k2);
        check("ovr_first", 32'(rx_log[bd]), 32'h11);
        check("ovr_count", 32'(ovr_cnt - bo), 32'd1);
        check("ovr_timing", 32'(ovr_cyc - k2), 32'(LAT));
        check("ovr_data", 32'(o_rx_d), 32'h22);
        check("ovr_valid", 32'(o_rx_valid), 32'd1);
        check("ovr_ferr", 32'(ferr_cnt - bf), 32'd0);
        i_rx_ready = 1'b1;
        idle(2);
        check("ovr_consumed", 32'(o_rx_valid), 32'd0);

        // Reset in the middle of DATA of 0x5A, released with the line low
        bd = rx_log.size(); bf = ferr_cnt; bo = ovr_cnt;
        i_rx_d = 1'b0;
        idle(CPB);
        drive_bit(1'b0);
        drive_bit(1'b1);
        i_rx_d = 1'b0;
        idle(200);
        check("mid_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2000);
        check("mrst_busy", 32'(o_busy), 32'd0);
        check("mrst_valid", 32'(o_rx_valid), 32'd0);
        check("mrst_rx_d", 32'(o_rx_d), 32'h00);
        check("mrst_ferr", 32'(ferr_cnt - bf), 32'd0);
        check("mrst_ovr", 32'(ovr_cnt - bo), 32'd0);
        check("mrst_count", 32'(rx_log.size() - bd), 32'd0);
        i_rx_d = 1'b1;
        idle(CPB);
        send_frame(8'h5A, 1'b1, k1);
        check("mrst_rx_count", 32'(rx_log.size() - bd), 32'd1);
        check("mrst_rx_data", 32'(rx_log[rx_log.size() - 1]), 32'h5A);
        check("mrst_latency", 32'(rise_cyc - k1), 32'(LAT));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
